// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sweep states and depth helper for dmem_sweep_bank
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/dmem_sweep_fsm.sv
// dmem_sweep_fsm: clear sequencer owning state, sweep pointer, Busy and Done
module dmem_sweep_fsm
    import dmem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearReq,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Ptr
);
    state_t state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    always_comb begin
        ptr_d   = state_q == CLEAR ? ptr_q + 1'b1 : (state_q == IDLE && ClearReq) ? '0 : ptr_q;
        state_d = state_q == CLEAR ? ((&ptr_q) ? DONE : CLEAR) :
                  state_q == DONE  ? IDLE : (ClearReq ? CLEAR : IDLE);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
    assign Busy = state_q == CLEAR;
    assign Done = state_q == DONE;
    assign Ptr  = ptr_q;
endmodule

// File: rtl/dmem_sweep_bank.sv
// dmem_sweep_bank: single-port data memory with hardware clear sweep
// Optional even-parity storage enabled by defining DMEM_SWEEP_PARITY_EN.
module dmem_sweep_bank
    import dmem_pkg::*;
#(
    parameter int          DW        = 8,
    parameter int          AW        = 8,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearReq,
    input  logic          WriteEn,
    input  logic [AW-1:0] Addr,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          Busy,
    output logic          Done,
    output logic          WrReject,
    output logic          ParityErr
);
    localparam int DEPTH = depth(AW);
`ifdef DMEM_SWEEP_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    logic [MW-1:0] core [DEPTH];
    logic [MW-1:0] wr_word, rd_word;
    logic [DW-1:0] wr_data, data_q;
    logic [AW-1:0] ptr;
    logic          rej_q;
    dmem_sweep_fsm #(.AW(AW)) u_fsm (
        .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq),
        .Busy(Busy), .Done(Done), .Ptr(ptr)
    );
    assign wr_data = Busy ? CLEAR_VAL : DataIn;
`ifdef DMEM_SWEEP_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign rd_word = core[Addr];
    // Sweep owns the port while Busy; stores are dropped, not deferred
    always_ff @(posedge Clk) begin
        if (Busy) core[ptr] <= wr_word;
        else if (WriteEn) core[Addr] <= wr_word;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
            rej_q  <= 1'b0;
        end else begin
            data_q <= Busy ? CLEAR_VAL : rd_word[DW-1:0];
            rej_q  <= WriteEn && Busy;
        end
    end
`ifdef DMEM_SWEEP_PARITY_EN
    logic perr_q;
    always_ff @(posedge Clk) begin
        if (Reset) perr_q <= 1'b0;
        else perr_q <= !Busy && (^rd_word);
    end
    assign ParityErr = perr_q;
`else
    assign ParityErr = 1'b0;
`endif
    assign DataOut  = data_q;
    assign WrReject = rej_q;
endmodule
